// File: rtl/regfile_writeback_queue.sv
// Write-back queue for the 32x32 register file.
// Accepted requests are buffered in an in-order FIFO. The FIFO drains one
// entry per cycle into a registered write port (Aw/Dw/WrEn). Both read
// ports get combinational forwarding from the queue and the output register.
module regfile_writeback_queue #(
   parameter int DEPTH      = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [ADDR_WIDTH-1:0]          in_addr,
   input  logic [DATA_WIDTH-1:0]          in_data,
   input  logic                           stall,
   input  logic                           flush,
   output logic [ADDR_WIDTH-1:0]          Aw,
   output logic [DATA_WIDTH-1:0]          Dw,
   output logic                           WrEn,
   input  logic [ADDR_WIDTH-1:0]          Aa,
   input  logic [ADDR_WIDTH-1:0]          Ab,
   output logic                           fwd_hit_a,
   output logic [DATA_WIDTH-1:0]          fwd_data_a,
   output logic                           fwd_hit_b,
   output logic [DATA_WIDTH-1:0]          fwd_data_b,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] aw_q, aw_d;
   logic [DATA_WIDTH-1:0] dw_q, dw_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q [DEPTH];
   logic [ADDR_WIDTH-1:0] mem_addr_d [DEPTH];
   logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_data_d [DEPTH];

   logic push;
   logic pop;

   assign in_ready = (count_q < CNT_W'(DEPTH));
   assign count    = count_q;
   assign WrEn     = wr_en_q;
   assign Aw       = aw_q;
   assign Dw       = dw_q;

   // Writes to register 0 are consumed but never queued; flush blocks both sides.
   assign push = in_valid & in_ready & (in_addr != '0) & ~flush;
   assign pop  = (count_q != '0) & ~stall & ~flush;

   // Next-state for pointers, occupancy, output register and storage.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      wr_en_d    = 1'b0;
      aw_d       = aw_q;
      dw_d       = dw_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;

      if (push) begin
         mem_addr_d[wr_ptr_q] = in_addr;
         mem_data_d[wr_ptr_q] = in_data;
         wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end

      if (pop) begin
         aw_d     = mem_addr_q[rd_ptr_q];
         dw_d     = mem_data_q[rd_ptr_q];
         wr_en_d  = 1'b1;
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (flush) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end
   end

   // Control and output-register flops with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         wr_en_q  <= 1'b0;
         aw_q     <= '0;
         dw_q     <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         wr_en_q  <= wr_en_d;
         aw_q     <= aw_d;
         dw_q     <= dw_d;
      end
   end

   // Queue storage; contents are only meaningful under count, so no reset.
   always_ff @(posedge clk) begin
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
   end

   // Forwarding: scan oldest (output register) to youngest (tail) so the
   // last match wins, which yields the youngest pending value.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx        = '0;
      fwd_hit_a  = 1'b0;
      fwd_data_a = '0;
      fwd_hit_b  = 1'b0;
      fwd_data_b = '0;

      if (wr_en_q && (Aa != '0) && (aw_q == Aa)) begin
         fwd_hit_a  = 1'b1;
         fwd_data_a = dw_q;
      end
      if (wr_en_q && (Ab != '0) && (aw_q == Ab)) begin
         fwd_hit_b  = 1'b1;
         fwd_data_b = dw_q;
      end

      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = rd_ptr_q + PTR_W'(i);
         if (CNT_W'(i) < count_q) begin
            if ((Aa != '0) && (mem_addr_q[idx] == Aa)) begin
               fwd_hit_a  = 1'b1;
               fwd_data_a = mem_data_q[idx];
            end
            if ((Ab != '0) && (mem_addr_q[idx] == Ab)) begin
               fwd_hit_b  = 1'b1;
               fwd_data_b = mem_data_q[idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_regfile_writeback_queue;

   localparam int DEPTH = 4;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_addr;
   logic [DW-1:0] in_data;
   logic          stall;
   logic          flush;
   logic [AW-1:0] Aw;
   logic [DW-1:0] Dw;
   logic          WrEn;
   logic [AW-1:0] Aa;
   logic [AW-1:0] Ab;
   logic          fwd_hit_a;
   logic [DW-1:0] fwd_data_a;
   logic          fwd_hit_b;
   logic [DW-1:0] fwd_data_b;
   logic [CW-1:0] count;

   int n_tests = 0;
   int n_fail  = 0;

   regfile_writeback_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
      .stall(stall), .flush(flush),
      .Aw(Aw), .Dw(Dw), .WrEn(WrEn),
      .Aa(Aa), .Ab(Ab),
      .fwd_hit_a(fwd_hit_a), .fwd_data_a(fwd_data_a),
      .fwd_hit_b(fwd_hit_b), .fwd_data_b(fwd_data_b),
      .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } ent_t;

   ent_t          mq[$];
   logic          m_wren = 1'b0;
   logic [AW-1:0] m_aw   = '0;
   logic [DW-1:0] m_dw   = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mq.delete();
         m_wren = 1'b0;
         m_aw   = '0;
         m_dw   = '0;
      end else begin
         int  occ;
         bit  acc;
         ent_t e;
         occ = mq.size();
         acc = in_valid && (occ < DEPTH);
         if (flush) begin
            mq.delete();
            m_wren = 1'b0;
         end else begin
            if (occ > 0 && !stall) begin
               e      = mq.pop_front();
               m_wren = 1'b1;
               m_aw   = e.addr;
               m_dw   = e.data;
            end else begin
               m_wren = 1'b0;
            end
            if (acc && in_addr != 0) begin
               e.addr = in_addr;
               e.data = in_data;
               mq.push_back(e);
            end
         end
      end
   end

   function automatic void model_fwd(input logic [AW-1:0] a, output logic hit,
                                     output logic [DW-1:0] d);
      hit = 1'b0;
      d   = '0;
      if (a == 0) return;
      for (int k = mq.size() - 1; k >= 0; k--) begin
         if (mq[k].addr == a) begin
            hit = 1'b1;
            d   = mq[k].data;
            return;
         end
      end
      if (m_wren && m_aw == a) begin
         hit = 1'b1;
         d   = m_dw;
      end
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      logic          eh_a, eh_b;
      logic [DW-1:0] ed_a, ed_b;
      model_fwd(Aa, eh_a, ed_a);
      model_fwd(Ab, eh_b, ed_b);
      check("m_count",    64'(count),      64'(mq.size()));
      check("m_in_ready", 64'(in_ready),   64'(mq.size() < DEPTH));
      check("m_wren",     64'(WrEn),       64'(m_wren));
      check("m_aw",       64'(Aw),         64'(m_aw));
      check("m_dw",       64'(Dw),         64'(m_dw));
      check("m_hit_a",    64'(fwd_hit_a),  64'(eh_a));
      check("m_data_a",   64'(fwd_data_a), 64'(ed_a));
      check("m_hit_b",    64'(fwd_hit_b),  64'(eh_b));
      check("m_data_b",   64'(fwd_data_b), 64'(ed_b));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [AW-1:0] a, input logic [DW-1:0] d);
      in_valid = 1'b1;
      in_addr  = a;
      in_data  = d;
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
      in_addr  = '0;
      in_data  = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- directed stimulus ----------------
   initial begin
      reset = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      Aa = '0;
      Ab = '0;
      idle_in();
      tick();
      tick();
      check("rst_wren",  64'(WrEn),     64'd0);
      check("rst_count", 64'(count),    64'd0);
      check("rst_ready", 64'(in_ready), 64'd1);
      reset = 1'b0;
      tick();

      // Basic drain: accepted at edge 1, presented after edge 2.
      req(5'd2, 32'd42);
      tick();
      check("drain_cnt1", 64'(count), 64'd1);
      check("drain_we0",  64'(WrEn),  64'd0);
      idle_in();
      tick();
      check("drain_we1", 64'(WrEn),  64'd1);
      check("drain_aw",  64'(Aw),    64'd2);
      check("drain_dw",  64'(Dw),    64'd42);
      check("drain_cnt", 64'(count), 64'd0);
      tick();
      check("drain_we2", 64'(WrEn),  64'd0);
      check("drain_dwh", 64'(Dw),    64'd42);

      // Full / back-pressure, then in-order drain.
      stall = 1'b1;
      req(5'd1, 32'd10); tick();
      req(5'd3, 32'd11); tick();
      req(5'd4, 32'd12); tick();
      req(5'd5, 32'd13); tick();
      check("full_cnt",   64'(count),    64'd4);
      check("full_ready", 64'(in_ready), 64'd0);
      req(5'd6, 32'd14); tick();
      check("full_cnt5",  64'(count),    64'd4);
      idle_in();
      stall = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("full_we", 64'(WrEn), 64'd1);
         check("full_dw", 64'(Dw),   64'(10 + i));
      end
      tick();
      check("full_we_end", 64'(WrEn),  64'd0);
      check("full_cnt0",   64'(count), 64'd0);

      // Register zero is dropped.
      req(5'd0, 32'd12); tick();
      check("r0_cnt", 64'(count), 64'd0);
      req(5'd7, 32'd5);  tick();
      check("r0_cnt1", 64'(count), 64'd1);
      idle_in();
      Aa = 5'd0;
      tick();
      check("r0_we", 64'(WrEn),      64'd1);
      check("r0_aw", 64'(Aw),        64'd7);
      check("r0_dw", 64'(Dw),        64'd5);
      check("r0_ha", 64'(fwd_hit_a), 64'd0);
      tick();

      // Forwarding: youngest match wins.
      stall = 1'b1;
      req(5'd17, 32'd29); tick();
      req(5'd17, 32'd55); tick();
      idle_in();
      Aa = 5'd17;
      Ab = 5'd17;
      #1;
      check("fw_ha", 64'(fwd_hit_a),  64'd1);
      check("fw_hb", 64'(fwd_hit_b),  64'd1);
      check("fw_da", 64'(fwd_data_a), 64'd55);
      check("fw_db", 64'(fwd_data_b), 64'd55);
      stall = 1'b0;
      tick();
      check("fw1_dw", 64'(Dw),         64'd29);
      check("fw1_da", 64'(fwd_data_a), 64'd55);
      tick();
      check("fw2_dw", 64'(Dw),         64'd55);
      check("fw2_da", 64'(fwd_data_a), 64'd55);
      tick();
      check("fw3_ha", 64'(fwd_hit_a),  64'd0);
      check("fw3_da", 64'(fwd_data_a), 64'd0);
      Aa = '0;
      Ab = '0;

      // Flush with stall released at the same edge.
      stall = 1'b1;
      req(5'd2, 32'd36); tick();
      req(5'd3, 32'd45); tick();
      idle_in();
      stall = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_we",  64'(WrEn),  64'd0);
      check("fl_cnt", 64'(count), 64'd0);
      tick();
      check("fl_we2", 64'(WrEn),  64'd0);

      // Flush while a write is presented: that write still completes.
      req(5'd9, 32'd7); tick();
      idle_in();
      tick();
      check("flw_we", 64'(WrEn), 64'd1);
      flush = 1'b1;
      req(5'd10, 32'd1);
      Aa = 5'd9;
      #1;
      check("flw_we_keep", 64'(WrEn),      64'd1);
      check("flw_aw",      64'(Aw),        64'd9);
      check("flw_dw",      64'(Dw),        64'd7);
      check("flw_ha",      64'(fwd_hit_a), 64'd1);
      check("flw_ready",   64'(in_ready),  64'd1);
      tick();
      flush = 1'b0;
      idle_in();
      check("flw_we_off", 64'(WrEn),  64'd0);
      check("flw_cnt",    64'(count), 64'd0);
      Aa = '0;

      // Back-to-back stream: enqueue and pop in the same cycle.
      for (int i = 0; i < 6; i++) begin
         req(AW'(3 + i), DW'(100 + i));
         Ab = AW'(3 + i);
         tick();
      end
      check("str_cnt", 64'(count), 64'd1);
      check("str_dw",  64'(Dw),    64'd104);
      idle_in();
      tick();
      check("str_last", 64'(Dw), 64'd105);
      tick();
      Ab = '0;

      // Asynchronous reset in the middle of a cycle.
      stall = 1'b1;
      req(5'd11, 32'd1); tick();
      req(5'd12, 32'd2); tick();
      req(5'd13, 32'd3); tick();
      idle_in();
      stall = 1'b0;
      tick();
      #1;
      reset = 1'b1;
      #1;
      check("arst_we",    64'(WrEn),     64'd0);
      check("arst_aw",    64'(Aw),       64'd0);
      check("arst_dw",    64'(Dw),       64'd0);
      check("arst_cnt",   64'(count),    64'd0);
      check("arst_ready", 64'(in_ready), 64'd1);
      tick();
      reset = 1'b0;
      req(5'd20, 32'd77); tick();
      idle_in();
      tick();
      check("post_aw", 64'(Aw), 64'd20);
      check("post_dw", 64'(Dw), 64'd77);
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
